// File: rtl/trace_packet_framer_pkg.sv
// Shared types and constants for the trace packet framer.
package cms_trace_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } framer_state_e;

    // Width of the cycle stamp that can overlay the top of each pushed word.
    localparam int unsigned TS_WIDTH = 64;

    // Upper bound on DATA_WIDTH.
    // Users slice the low DATA_WIDTH bits of TERMINATOR_WORD.
    localparam int unsigned MAX_DATA_WIDTH = 4096;
    localparam logic [MAX_DATA_WIDTH-1:0] TERMINATOR_WORD = '0;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned in_flight_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/trace_packet_framer_if.sv
// Push bus between the framer and the downstream trace FIFO: sample input, pushed word, credit return.
interface trace_packet_framer_if #(
    parameter int unsigned DATA_WIDTH = 1024
);
    logic                  trace_valid;
    logic [DATA_WIDTH-1:0] trace_data;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] data_pkt;
    logic                  tlast;
    logic                  consumed;

    // Framer side: takes samples and credit returns, drives the push strobe and word.
    modport master (
        input  trace_valid,
        input  trace_data,
        input  consumed,
        output write_enable,
        output data_pkt,
        output tlast
    );

    // Environment / FIFO side.
    modport slave (
        output trace_valid,
        output trace_data,
        output consumed,
        input  write_enable,
        input  data_pkt,
        input  tlast
    );
endinterface

// File: rtl/trace_credit_counter.sv
// Tracks words pushed downstream but not yet consumed, and flags credit returns with nothing in flight.
module trace_credit_counter
    import cms_trace_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned IFW        = in_flight_width(FIFO_DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           accept,
    input  logic           consumed,
    output logic [IFW-1:0] in_flight,
    output logic           has_credit,
    output logic           credit_err
);

    logic [IFW-1:0] in_flight_q, in_flight_d;
    logic           err_q, err_d;
    logic           dec;

    // Next occupancy: a credit return with nothing in flight is ignored and flagged.
    always_comb begin
        dec         = consumed && (in_flight_q != '0);
        in_flight_d = in_flight_q;
        unique case ({accept, dec})
            2'b10:   in_flight_d = in_flight_q + IFW'(1);
            2'b01:   in_flight_d = in_flight_q - IFW'(1);
            default: in_flight_d = in_flight_q;
        endcase
        err_d = err_q | (consumed && (in_flight_q == '0));
    end

    // Occupancy and sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_flight_q <= '0;
            err_q       <= 1'b0;
        end else begin
            in_flight_q <= in_flight_d;
            err_q       <= err_d;
        end
    end

    assign in_flight  = in_flight_q;
    assign has_credit = in_flight_q < IFW'(FIFO_DEPTH);
    assign credit_err = err_q;

endmodule

// File: rtl/trace_packet_framer.sv
// Frames per-cycle trace samples into packets for the downstream trace FIFO.
// Config macro: TRACE_FRAMER_TIMESTAMP_EN overlays a 64-bit cycle stamp on the top of each pushed word.
module trace_packet_framer
    import cms_trace_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1024,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic [CNT_W-1:0]                   tlast_interval,
    input  logic                               force_tlast,
    trace_packet_framer_if.master              bus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    in_flight,
    output logic [CNT_W-1:0]                   dropped_count,
    output logic [CNT_W-1:0]                   packet_count,
    output logic                               credit_err
);

    framer_state_e         state_q, state_d;
    logic [CNT_W-1:0]      item_cnt_q, item_cnt_d;
    logic                  pend_q, pend_d;
    logic                  we_q, tlast_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_W-1:0]      drop_q, pkt_q;

    logic                  has_credit;
    logic                  accept_item, drop_item, push, push_last;
    logic [DATA_WIDTH-1:0] push_word, push_data;

    // Samples are only taken while capture is enabled in RUN; a disabled RUN cycle is the exit cycle.
    always_comb begin
        accept_item = (state_q == StRun) && enable && bus.trace_valid && has_credit;
        drop_item   = (state_q == StRun) && enable && bus.trace_valid && !has_credit;
    end

    // Framing FSM: packet position, pending force, terminator on exit from a partial packet.
    always_comb begin
        state_d    = state_q;
        item_cnt_d = item_cnt_q;
        pend_d     = pend_q;
        push       = 1'b0;
        push_last  = 1'b0;
        push_word  = bus.trace_data;

        if (accept_item) begin
            push = 1'b1;
            // ">=" closes the packet at once if the interval was lowered mid-packet.
            push_last = pend_q || force_tlast ||
                        ((tlast_interval != '0) && (item_cnt_q >= tlast_interval - CNT_W'(1)));
            item_cnt_d = push_last ? '0 : item_cnt_q + CNT_W'(1);
            pend_d     = 1'b0;
        end else if (force_tlast) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StRun;
            end
            StRun: begin
                if (!enable) state_d = (item_cnt_q != '0) ? StFlush : StIdle;
            end
            StFlush: begin
                if (has_credit) begin
                    push       = 1'b1;
                    push_last  = 1'b1;
                    push_word  = TERMINATOR_WORD[DATA_WIDTH-1:0];
                    item_cnt_d = '0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef TRACE_FRAMER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;

    // Free-running cycle stamp, wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + TS_WIDTH'(1);
    end

    // Stamp taken in the accept cycle replaces the top bits of the word.
    always_comb begin
        push_data                             = push_word;
        push_data[DATA_WIDTH-1 -: TS_WIDTH]   = ts_q;
    end
`else
    assign push_data = push_word;
`endif

    // State, counters and registered push outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            item_cnt_q <= '0;
            pend_q     <= 1'b0;
            we_q       <= 1'b0;
            tlast_q    <= 1'b0;
            data_q     <= '0;
            drop_q     <= '0;
            pkt_q      <= '0;
        end else begin
            state_q    <= state_d;
            item_cnt_q <= item_cnt_d;
            pend_q     <= pend_d;
            we_q       <= push;
            tlast_q    <= push && push_last;
            if (push) data_q <= push_data;
            if (drop_item && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
            if (push && push_last) pkt_q <= pkt_q + CNT_W'(1);
        end
    end

    trace_credit_counter #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_credit (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept     (push),
        .consumed   (bus.consumed),
        .in_flight  (in_flight),
        .has_credit (has_credit),
        .credit_err (credit_err)
    );

    assign bus.write_enable = we_q;
    assign bus.data_pkt     = data_q;
    assign bus.tlast        = tlast_q;
    assign dropped_count    = drop_q;
    assign packet_count     = pkt_q;

endmodule

// File: tb/tb_trace_packet_framer.sv
// Randomized and directed bench for trace_packet_framer against a behavioural packet model.
module tb_trace_packet_framer;

    localparam int unsigned DW    = 128;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned CW    = 32;
    localparam int unsigned IFW   = 6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic           force_tlast;
    logic [CW-1:0]  tlast_interval;
    logic [IFW-1:0] in_flight;
    logic [CW-1:0]  dropped_count;
    logic [CW-1:0]  packet_count;
    logic           credit_err;

    always #5 clk = ~clk;

    trace_packet_framer_if #(.DATA_WIDTH(DW)) bus ();

    trace_packet_framer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .tlast_interval (tlast_interval),
        .force_tlast    (force_tlast),
        .bus            (bus),
        .in_flight      (in_flight),
        .dropped_count  (dropped_count),
        .packet_count   (packet_count),
        .credit_err     (credit_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: capture mode, position in packet, credits, counters, expected outputs.
    int              m_mode;      // 0 idle, 1 capturing, 2 closing a partial packet
    longint unsigned m_items;     // items already in the open packet
    bit              m_pend;
    int              m_inflight;
    longint unsigned m_drop;
    logic [CW-1:0]   m_pkts;
    bit              m_err, m_we, m_tlast;
    logic [DW-1:0]   m_data;
    logic [63:0]     m_ts;

    // Observed pushes within a directed step.
    int              pushes;
    longint unsigned tlast_mask;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic model_edge();
        bit            has, acc, drp, term, last;
        int            old_inflight;
        longint unsigned old_items;
        logic [DW-1:0] word;
        if (!rst_n) begin
            m_mode = 0; m_items = 0; m_pend = 0; m_inflight = 0; m_drop = 0; m_pkts = '0;
            m_err = 0; m_we = 0; m_tlast = 0; m_data = '0; m_ts = '0;
            return;
        end
        has          = m_inflight < DEPTH;
        old_items    = m_items;
        old_inflight = m_inflight;
        acc  = (m_mode == 1) && enable && bus.trace_valid && has;
        drp  = (m_mode == 1) && enable && bus.trace_valid && !has;
        term = (m_mode == 2) && has;
        last = 0;
        word = '0;
        if (acc) begin
            last = m_pend || force_tlast ||
                   (tlast_interval != 0 && m_items + 1 >= longint'(tlast_interval));
            word    = bus.trace_data;
            m_items = last ? 0 : m_items + 1;
            m_pend  = 0;
        end else if (force_tlast) begin
            m_pend = 1;
        end
        if (term) begin
            word    = '0;
            last    = 1;
            m_items = 0;
        end
`ifdef TRACE_FRAMER_TIMESTAMP_EN
        word[DW-1 -: 64] = m_ts;
`endif
        m_we    = acc || term;
        m_tlast = m_we && last;
        if (m_we) m_data = word;
        if (drp && m_drop != 64'hFFFF_FFFF) m_drop++;
        if (m_tlast) m_pkts = m_pkts + 1;
        if (bus.consumed && old_inflight == 0) m_err = 1;
        if (m_we) m_inflight++;
        if (bus.consumed && old_inflight != 0) m_inflight--;
        case (m_mode)
            0:       if (enable) m_mode = 1;
            1:       if (!enable) m_mode = (old_items != 0) ? 2 : 0;
            default: if (term) m_mode = 0;
        endcase
        m_ts = m_ts + 1;
    endtask

    // One clock: advance the model on the driven inputs, then compare just after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("write_enable", DW'(bus.write_enable), DW'(m_we));
        check("tlast", DW'(bus.tlast), DW'(m_tlast));
        check("data_pkt", bus.data_pkt, m_data);
        check("in_flight", DW'(in_flight), DW'(m_inflight));
        check("dropped_count", DW'(dropped_count), DW'(m_drop));
        check("packet_count", DW'(packet_count), DW'(m_pkts));
        check("credit_err", DW'(credit_err), DW'(m_err));
        if (bus.write_enable) begin
            if (bus.tlast) tlast_mask |= 64'(1) << pushes;
            pushes++;
        end
    endtask

    task automatic clear_obs();
        pushes     = 0;
        tlast_mask = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; force_tlast = 1'b0;
        bus.trace_valid = 1'b0; bus.consumed = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; force_tlast = 1'b0; tlast_interval = '0;
        bus.trace_valid = 1'b0; bus.trace_data = '0; bus.consumed = 1'b0;
        clear_obs();
        repeat (3) step();
        check("reset_we", DW'(bus.write_enable), DW'(0));
        check("reset_pkts", DW'(packet_count), DW'(0));
        rst_n = 1'b1;

        // Interval 4, ten back-to-back samples with the FIFO draining.
        tlast_interval = 4; enable = 1'b1;
        step();
        clear_obs();
        for (int i = 0; i < 10; i++) begin
            bus.trace_valid = 1'b1; bus.trace_data = rand_word();
            bus.consumed = (m_inflight != 0);
            step();
        end
        check("t1_pushes", DW'(pushes), DW'(10));
        check("t1_tlast_items", DW'(tlast_mask), DW'(64'h88));
        check("t1_packet_count", DW'(packet_count), DW'(2));
        bus.trace_valid = 1'b0; enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.consumed = (m_inflight != 0);
            step();
        end
        do_reset();

        // No credit returns: 32 pushes, 8 drops, then a forced tlast during a drop.
        tlast_interval = 0; enable = 1'b1;
        step();
        clear_obs();
        for (int i = 0; i < 40; i++) begin
            bus.trace_valid = 1'b1; bus.trace_data = rand_word();
            step();
        end
        check("t2_pushes", DW'(pushes), DW'(32));
        check("t2_dropped", DW'(dropped_count), DW'(8));
        check("t2_in_flight", DW'(in_flight), DW'(32));
        force_tlast = 1'b1; bus.trace_data = rand_word();
        step();
        force_tlast = 1'b0; bus.trace_valid = 1'b0; bus.consumed = 1'b1;
        step();
        bus.consumed = 1'b0; bus.trace_valid = 1'b1; bus.trace_data = rand_word();
        step();
        check("t2_accept_after_credit", DW'(bus.write_enable), DW'(1));
        check("t2_forced_tlast", DW'(bus.tlast), DW'(1));
        check("t2_dropped_9", DW'(dropped_count), DW'(9));
        bus.trace_valid = 1'b0;
        do_reset();

        // Interval 0, force on item 3, then a terminator for the open packet.
        enable = 1'b1;
        step();
        clear_obs();
        for (int i = 1; i <= 5; i++) begin
            bus.trace_valid = 1'b1; bus.trace_data = rand_word();
            force_tlast = (i == 3); bus.consumed = (m_inflight != 0);
            step();
        end
        check("t3_pushes", DW'(pushes), DW'(5));
        check("t3_tlast_item3", DW'(tlast_mask), DW'(64'h4));
        force_tlast = 1'b0; bus.trace_valid = 1'b0; enable = 1'b0; bus.consumed = 1'b0;
        clear_obs();
        repeat (3) step();
        check("t3_one_terminator", DW'(pushes), DW'(1));
        check("t3_terminator_last", DW'(tlast_mask), DW'(1));
        enable = 1'b1; step();
        enable = 1'b0; step(); step();
        check("t3_no_empty_terminator", DW'(pushes), DW'(1));
        do_reset();

        // Credit return with nothing in flight, then reset mid-packet.
        bus.consumed = 1'b1;
        step();
        check("t4_credit_err", DW'(credit_err), DW'(1));
        check("t4_in_flight_0", DW'(in_flight), DW'(0));
        bus.consumed = 1'b0; enable = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            bus.trace_valid = 1'b1; bus.trace_data = rand_word();
            step();
        end
        rst_n = 1'b0;
        step();
        check("t4_rst_we", DW'(bus.write_enable), DW'(0));
        check("t4_rst_in_flight", DW'(in_flight), DW'(0));
        check("t4_rst_err", DW'(credit_err), DW'(0));
        check("t4_rst_data", bus.data_pkt, DW'(0));
        rst_n = 1'b1; bus.trace_valid = 1'b0; enable = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if (c % 60 == 0) tlast_interval = $urandom_range(0, 5);
            if (c % 7 == 0) enable = ($urandom_range(0, 5) != 0);
            bus.trace_valid = enable && ($urandom_range(0, 2) != 0);
            bus.trace_data  = rand_word();
            force_tlast     = enable && ($urandom_range(0, 9) == 0);
            bus.consumed    = ($urandom_range(0, 1) == 1);
            rst_n           = ($urandom_range(0, 399) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
